march_sequencer: RTL and testbench

Self-contained March C- test sequencer for the BIST memory path. It drives the memory directly with address, read/write strobes and background data. It compares read data against the expected background and reports pass/fail plus optional first-failure diagnostics. It replaces the hand-wired controller/address/data-generator chain with one scheduling block that owns the whole test sequence.

---
 rtl/march_pkg.sv | 48 ++++
 rtl/march_addr_counter.sv | 32 +++
 rtl/march_sequencer.sv | 158 +++++++++++++++
 tb/tb_march_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/march_pkg.sv
// Shared types and per-element March C- tables for the march_sequencer slice.
// Each element table is a bit vector indexed by the element number (0..5).
package march_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int ELEM_COUNT = 6;

  localparam logic [2:0] ELEM_W0      = 3'd0;
  localparam logic [2:0] ELEM_R0W1_UP = 3'd1;
  localparam logic [2:0] ELEM_R1W0_UP = 3'd2;
  localparam logic [2:0] ELEM_R0W1_DN = 3'd3;
  localparam logic [2:0] ELEM_R1W0_DN = 3'd4;
  localparam logic [2:0] ELEM_R0      = 3'd5;

  // Bit e of each table describes element e.
  localparam logic [ELEM_COUNT-1:0] ELEM_DIR_DOWN = 6'b011000;
  localparam logic [ELEM_COUNT-1:0] ELEM_TWO_OPS  = 6'b011110;
  localparam logic [ELEM_COUNT-1:0] ELEM_HAS_READ = 6'b111110;
  localparam logic [ELEM_COUNT-1:0] ELEM_RVAL     = 6'b010100;
  localparam logic [ELEM_COUNT-1:0] ELEM_WVAL     = 6'b001010;

  function automatic logic elem_down(input logic [2:0] e);
    return (e < 3'(ELEM_COUNT)) ? ELEM_DIR_DOWN[e] : 1'b0;
  endfunction

  function automatic logic elem_two_ops(input logic [2:0] e);
    return (e < 3'(ELEM_COUNT)) ? ELEM_TWO_OPS[e] : 1'b0;
  endfunction

  function automatic logic elem_has_read(input logic [2:0] e);
    return (e < 3'(ELEM_COUNT)) ? ELEM_HAS_READ[e] : 1'b0;
  endfunction

  function automatic logic elem_rval(input logic [2:0] e);
    return (e < 3'(ELEM_COUNT)) ? ELEM_RVAL[e] : 1'b0;
  endfunction

  function automatic logic elem_wval(input logic [2:0] e);
    return (e < 3'(ELEM_COUNT)) ? ELEM_WVAL[e] : 1'b0;
  endfunction

endpackage

// File: rtl/march_addr_counter.sv
// Up/down address counter with load-to-0 / load-to-max and a combinational
// terminal flag for the current direction.
module march_addr_counter #(
  parameter int a_width = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_zero,
  input  logic               load_max,
  input  logic               step,
  input  logic               down,
  output logic [a_width-1:0] count,
  output logic               terminal
);

  localparam logic [a_width-1:0] ONE = {{(a_width-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load_zero) begin
      count <= '0;
    end else if (load_max) begin
      count <= '1;
    end else if (step) begin
      count <= down ? (count - ONE) : (count + ONE);
    end
  end

  assign terminal = down ? (count == '0) : (count == '1);

endmodule

// File: rtl/march_sequencer.sv
// March C- BIST sequencer: drives the memory, compares reads one cycle later.
// Optional first-failure capture is enabled by defining MARCH_FAIL_LOG_EN.
module march_sequencer
  import march_pkg::*;
#(
  parameter int a_width = 4,
  parameter int width   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [a_width-1:0] mem_addr,
  output logic               mem_re,
  output logic               mem_we,
  output logic [width-1:0]   mem_wdata,
  input  logic [width-1:0]   mem_rdata,
  output logic [a_width-1:0] fail_addr,
  output logic [2:0]         fail_elem,
  output logic [width-1:0]   fail_mask
);

  state_t           state, next_state;
  logic [2:0]       elem_q, elem_d, elem_next;
  logic             phase_q, phase_d;
  logic             load_zero, load_max, step, terminal;
  logic             launch, is_read;
  logic             cmp_valid;
  logic [width-1:0] exp_word;
  logic             miscompare;

  march_addr_counter #(.a_width(a_width)) u_addr (
    .clk       (clk),
    .rst       (rst),
    .load_zero (load_zero),
    .load_max  (load_max),
    .step      (step),
    .down      (elem_down(elem_q)),
    .count     (mem_addr),
    .terminal  (terminal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      elem_q  <= ELEM_W0;
      phase_q <= 1'b0;
    end else begin
      state   <= next_state;
      elem_q  <= elem_d;
      phase_q <= phase_d;
    end
  end

  // phase_q selects the second (write) op of a two-op element.
  always_comb begin
    next_state = state;
    elem_d     = elem_q;
    phase_d    = phase_q;
    elem_next  = elem_q + 3'd1;
    load_zero  = 1'b0;
    load_max   = 1'b0;
    step       = 1'b0;
    launch     = 1'b0;
    is_read    = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = RUN;
          launch     = 1'b1;
          elem_d     = ELEM_W0;
          phase_d    = 1'b0;
          load_zero  = 1'b1;
        end
      end
      RUN: begin
        is_read = elem_has_read(elem_q) && !phase_q;
        if (is_read) begin
          mem_re = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = {width{elem_wval(elem_q)}};
        end
        if (is_read && elem_two_ops(elem_q)) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!terminal) begin
            step = 1'b1;
          end else if (elem_q == ELEM_R0) begin
            next_state = DRAIN;
          end else begin
            elem_d = elem_next;
            if (elem_down(elem_next)) load_max = 1'b1;
            else                      load_zero = 1'b1;
          end
        end
      end
      DRAIN: next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);
  assign miscompare = cmp_valid && (mem_rdata != exp_word);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_valid <= 1'b0;
      exp_word  <= '0;
      fail      <= 1'b0;
    end else begin
      cmp_valid <= mem_re;
      exp_word  <= {width{elem_rval(elem_q)}};
      if (launch)          fail <= 1'b0;
      else if (miscompare) fail <= 1'b1;
    end
  end

`ifdef MARCH_FAIL_LOG_EN
  logic [a_width-1:0] exp_addr;
  logic [2:0]         exp_elem;

  // Only the first miscompare of a test is recorded (fail still low).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_addr  <= '0;
      exp_elem  <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_mask <= '0;
    end else begin
      exp_addr <= mem_addr;
      exp_elem <= elem_q;
      if (launch) begin
        fail_addr <= '0;
        fail_elem <= '0;
        fail_mask <= '0;
      end else if (miscompare && !fail) begin
        fail_addr <= exp_addr;
        fail_elem <= exp_elem;
        fail_mask <= mem_rdata ^ exp_word;
      end
    end
  end
`else
  assign fail_addr = '0;
  assign fail_elem = '0;
  assign fail_mask = '0;
`endif

endmodule

// File: tb/tb_march_sequencer.sv
// Directed bench for march_sequencer (N=16, width=4) with a behavioural memory
// that can inject a stuck-at-1 on bit 2 of address 5.
module tb_march_sequencer;

  localparam int NCYC = 165;

  logic       clk, rst, start;
  logic       busy, done, fail, mem_re, mem_we;
  logic [3:0] mem_addr, mem_wdata, mem_rdata, fail_addr, fail_mask;
  logic [2:0] fail_elem;

  logic [3:0] mem [0:15];
  logic       stuck;

  logic       cap_busy [0:NCYC];
  logic       cap_done [0:NCYC];
  logic       cap_fail [0:NCYC];
  logic       cap_re   [0:NCYC];
  logic       cap_we   [0:NCYC];
  logic [3:0] cap_addr [0:NCYC];
  logic [3:0] cap_wd   [0:NCYC];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [0:16];

  march_sequencer #(.a_width(4), .width(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem),
    .fail_mask (fail_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous write, registered read, optional stuck-at-1 on addr 5 bit 2
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr] | ((stuck && mem_addr == 4'd5) ? 4'b0100 : 4'b0000);
  end

  function automatic vec_t mk(input int c, input logic b, input logic d, input logic r,
                              input logic w, input logic [3:0] a, input logic [3:0] wd);
    vec_t v;
    v.cyc = c;
    v.exp = {b, d, r, w, a, wd};
    return v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start at the next edge (edge 0); start is dropped from cycle hold_until onward.
  task automatic applyStimulus(input int hold_until);
    start = 1'b1;
    for (int k = 1; k <= NCYC; k++) begin
      @(posedge clk);
      #1;
      if (k >= hold_until) start = 1'b0;
      cap_busy[k] = busy;
      cap_done[k] = done;
      cap_fail[k] = fail;
      cap_re[k]   = mem_re;
      cap_we[k]   = mem_we;
      cap_addr[k] = mem_addr;
      cap_wd[k]   = mem_wdata;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_outs"}, {busy, done, fail, mem_re, mem_we}, 0);
    checkOutput({tag, "_addr"}, mem_addr, 0);
    checkOutput({tag, "_wdata"}, mem_wdata, 0);
    checkOutput({tag, "_diag"}, {fail_addr, fail_elem, fail_mask}, 0);
  endtask

  task automatic checkDoneCycle(input string tag);
    int first;
    first = -1;
    for (int k = NCYC; k >= 1; k--) if (cap_done[k]) first = k;
    checkOutput({tag, "_done_cycle"}, first, 162);
  endtask

  initial begin
    int nreads, nwrites, nboth, busy_gaps;
    for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    mem_rdata = 4'h0;
    stuck = 1'b0;
    start = 1'b0;
    rst   = 1'b1;
    #2;
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    vecs[0]  = mk(1,   1, 0, 0, 1, 4'd0,  4'h0);
    vecs[1]  = mk(2,   1, 0, 0, 1, 4'd1,  4'h0);
    vecs[2]  = mk(16,  1, 0, 0, 1, 4'd15, 4'h0);
    vecs[3]  = mk(17,  1, 0, 1, 0, 4'd0,  4'h0);
    vecs[4]  = mk(18,  1, 0, 0, 1, 4'd0,  4'hF);
    vecs[5]  = mk(48,  1, 0, 0, 1, 4'd15, 4'hF);
    vecs[6]  = mk(49,  1, 0, 1, 0, 4'd0,  4'h0);
    vecs[7]  = mk(80,  1, 0, 0, 1, 4'd15, 4'h0);
    vecs[8]  = mk(81,  1, 0, 1, 0, 4'd15, 4'h0);
    vecs[9]  = mk(82,  1, 0, 0, 1, 4'd15, 4'hF);
    vecs[10] = mk(112, 1, 0, 0, 1, 4'd0,  4'hF);
    vecs[11] = mk(113, 1, 0, 1, 0, 4'd15, 4'h0);
    vecs[12] = mk(144, 1, 0, 0, 1, 4'd0,  4'h0);
    vecs[13] = mk(145, 1, 0, 1, 0, 4'd0,  4'h0);
    vecs[14] = mk(160, 1, 0, 1, 0, 4'd15, 4'h0);
    vecs[15] = mk(161, 1, 0, 0, 0, 4'd15, 4'h0);
    vecs[16] = mk(162, 0, 1, 0, 0, 4'd15, 4'h0);

    // Fault-free run with a one-cycle start pulse
    applyStimulus(1);
    for (int i = 0; i <= 16; i++) begin
      checkOutput($sformatf("vec_cycle_%0d", vecs[i].cyc),
                  {cap_busy[vecs[i].cyc], cap_done[vecs[i].cyc], cap_re[vecs[i].cyc],
                   cap_we[vecs[i].cyc], cap_addr[vecs[i].cyc], cap_wd[vecs[i].cyc]},
                  vecs[i].exp);
    end
    nreads = 0; nwrites = 0; nboth = 0;
    for (int k = 1; k <= NCYC; k++) begin
      if (cap_re[k]) nreads++;
      if (cap_we[k]) nwrites++;
      if (cap_re[k] && cap_we[k]) nboth++;
    end
    checkOutput("read_count", nreads, 80);
    checkOutput("write_count", nwrites, 80);
    checkOutput("re_we_overlap", nboth, 0);
    checkDoneCycle("clean");
    checkOutput("clean_fail", cap_fail[162], 0);
    for (int k = 81; k <= 112; k++) begin
      checkOutput($sformatf("elem3_addr_c%0d", k), cap_addr[k], 15 - (k - 81) / 2);
      checkOutput($sformatf("elem3_rewe_c%0d", k), {cap_re[k], cap_we[k]},
                  ((k - 81) % 2 == 0) ? 2 : 1);
    end

    // Stuck-at fault with start held through RUN
    stuck = 1'b1;
    applyStimulus(161);
    busy_gaps = 0;
    for (int k = 1; k <= 161; k++) if (!cap_busy[k]) busy_gaps++;
    checkOutput("held_busy_gaps", busy_gaps, 0);
    checkOutput("held_no_restart_c17", {cap_re[17], cap_addr[17]}, {1'b1, 4'd0});
    checkDoneCycle("held");
    checkOutput("fail_latency_c28", cap_fail[28], 0);
    checkOutput("fail_latency_c29", cap_fail[29], 1);
    checkOutput("stuck_fail_sticky", fail, 1);
    checkOutput("stuck_done", done, 1);
`ifdef MARCH_FAIL_LOG_EN
    checkOutput("fail_addr", fail_addr, 5);
    checkOutput("fail_elem", fail_elem, 1);
    checkOutput("fail_mask", fail_mask, 4);
`else
    checkOutput("fail_addr", fail_addr, 0);
    checkOutput("fail_elem", fail_elem, 0);
    checkOutput("fail_mask", fail_mask, 0);
`endif

    // Second start clears fail and done and reruns with identical timing
    stuck = 1'b0;
    applyStimulus(1);
    checkOutput("rerun_c1_clear", {cap_fail[1], cap_done[1], cap_busy[1]}, 3'b001);
    checkDoneCycle("rerun");
    checkOutput("rerun_fail", cap_fail[162], 0);
    checkOutput("rerun_diag", {fail_addr, fail_elem, fail_mask}, 0);

    // Reset asserted in cycle 50 of a run
    start = 1'b1;
    for (int k = 1; k <= 49; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    @(posedge clk);
    #2;
    checkOutput("pre_reset_busy", busy, 1);
    rst = 1'b1;
    #1;
    checkResetOutputs("midreset");
    #4;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("idle_after_reset_%0d", k), {busy, done, mem_re, mem_we}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
